perf_counter_unit: RTL



---
 rtl/perf_counter_unit_pkg.sv | 38 +++
 rtl/perf_counter_unit_event_counter.sv | 57 +++++
 rtl/perf_counter_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/perf_counter_unit_pkg.sv
// Shared types for the performance-counter slice.
// PerfCounterPath is the bundle exported through the debug register.
// Its fields are listed in event-index order, so numIC_Miss occupies the MSBs.
// Optional build macro: RSD_PERF_COUNTER_SATURATE_EN (see perf_event_counter).
package perf_counter_unit_pkg;

  localparam int unsigned PERF_COUNTER_NUM = 7;
  localparam int unsigned PERF_LANES       = 4;
  localparam int unsigned PERF_DATA_WIDTH  = 32;

  typedef logic [PERF_LANES-1:0] PerfEventLanePath;

  typedef enum logic [2:0] {
    PERF_IC_MISS            = 3'd0,
    PERF_LOAD_MISS          = 3'd1,
    PERF_STORE_MISS         = 3'd2,
    PERF_BRANCH_MISS        = 3'd3,
    PERF_BRANCH_MISS_DECODE = 3'd4,
    PERF_STLD_FWD_FAIL      = 3'd5,
    PERF_MEM_DEP_MISS       = 3'd6
  } PerfEventIndex;

  typedef struct packed {
    logic [PERF_DATA_WIDTH-1:0] numIC_Miss;
    logic [PERF_DATA_WIDTH-1:0] numLoadMiss;
    logic [PERF_DATA_WIDTH-1:0] numStoreMiss;
    logic [PERF_DATA_WIDTH-1:0] numBranchPredMiss;
    logic [PERF_DATA_WIDTH-1:0] numBranchPredMissDetectedOnDecode;
    logic [PERF_DATA_WIDTH-1:0] numStoreLoadForwardingFail;
    logic [PERF_DATA_WIDTH-1:0] numMemDepPredMiss;
  } PerfCounterPath;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HELD = 1'b1
  } snap_state_e;

endpackage

// File: rtl/perf_counter_unit_event_counter.sv
// perf_event_counter: one event counter plus its sticky overflow flag.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   inc        - increment for this cycle (0..LANES)
//   enable     - count when 1, hold when 0
//   clear      - synchronous clear of the count and the flag; wins over enable
//   value      - registered count
//   overflow   - sticky flag, set when the sum carries out of DATA_WIDTH
// Build macro RSD_PERF_COUNTER_SATURATE_EN: the count sticks at all-ones
// instead of wrapping. The flag is set in both builds.
module perf_event_counter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INC_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INC_WIDTH-1:0]  inc,
  input  logic                  enable,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] count_q;
  logic                  ovf_q;
  logic [DATA_WIDTH:0]   sum;

  // The extra top bit is the carry-out.
  assign sum = {1'b0, count_q} + {{(DATA_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (enable) begin
`ifdef RSD_PERF_COUNTER_SATURATE_EN
      // A count already at all-ones with inc>0 carries again, so it holds.
      if (sum[DATA_WIDTH]) begin
        count_q <= '1;
        ovf_q   <= 1'b1;
      end else begin
        count_q <= sum[DATA_WIDTH-1:0];
      end
`else
      count_q <= sum[DATA_WIDTH-1:0];
      if (sum[DATA_WIDTH]) ovf_q <= 1'b1;
`endif
    end
  end

  assign value    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: seven event counters with a req/ack snapshot for debug.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   countEnable       - 0 holds every counter
//   clear             - synchronous clear of the counters and overflow flags
//   events            - [counter][lane] event pulses; each lane adds 0 or 1
//   snapshotReq/Ack   - capture request and consumer acknowledge
//   snapshotValid     - snapshot holds a capture
//   perfCounter       - live counter values (registered)
//   snapshot          - captured counter values
//   overflow          - sticky per-counter carry-out flags
// Build macro RSD_PERF_COUNTER_SATURATE_EN selects saturating counters.
module perf_counter_unit
  import perf_counter_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LANES        = 4,
  parameter int unsigned NUM_COUNTERS = 7
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   countEnable,
  input  logic                                   clear,
  input  logic [NUM_COUNTERS-1:0][LANES-1:0]     events,
  input  logic                                   snapshotReq,
  input  logic                                   snapshotAck,
  output logic                                   snapshotValid,
  output PerfCounterPath                         perfCounter,
  output PerfCounterPath                         snapshot,
  output logic [NUM_COUNTERS-1:0]                overflow
);

  localparam int unsigned INC_WIDTH = $clog2(LANES + 1);

  logic [INC_WIDTH-1:0]  inc   [NUM_COUNTERS];
  logic [DATA_WIDTH-1:0] value [NUM_COUNTERS];
  snap_state_e           state;

  always_comb begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      inc[i] = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        inc[i] = inc[i] + INC_WIDTH'(events[i][l]);
      end
    end
  end

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    perf_event_counter #(
      .DATA_WIDTH (DATA_WIDTH),
      .INC_WIDTH  (INC_WIDTH)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[i]),
      .enable   (countEnable),
      .clear    (clear),
      .value    (value[i]),
      .overflow (overflow[i])
    );
  end

  always_comb begin
    perfCounter                                   = '0;
    perfCounter.numIC_Miss                        = value[PERF_IC_MISS];
    perfCounter.numLoadMiss                       = value[PERF_LOAD_MISS];
    perfCounter.numStoreMiss                      = value[PERF_STORE_MISS];
    perfCounter.numBranchPredMiss                 = value[PERF_BRANCH_MISS];
    perfCounter.numBranchPredMissDetectedOnDecode = value[PERF_BRANCH_MISS_DECODE];
    perfCounter.numStoreLoadForwardingFail        = value[PERF_STLD_FWD_FAIL];
    perfCounter.numMemDepPredMiss                 = value[PERF_MEM_DEP_MISS];
  end

  // Capture samples perfCounter before this edge's update, so a same-cycle
  // clear or increment is not reflected in the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SNAP_IDLE;
      snapshot      <= '0;
      snapshotValid <= 1'b0;
    end else begin
      case (state)
        SNAP_IDLE: begin
          if (snapshotReq) begin
            snapshot      <= perfCounter;
            snapshotValid <= 1'b1;
            state         <= SNAP_HELD;
          end
        end
        SNAP_HELD: begin
          if (snapshotAck) begin
            snapshotValid <= 1'b0;
            state         <= SNAP_IDLE;
          end
        end
        default: begin
          snapshotValid <= 1'b0;
          state         <= SNAP_IDLE;
        end
      endcase
    end
  end

endmodule
